battle_turn_timer: RTL and testbench
====================================

// Module: battle_turn_timer
// PURPOSE
//  Consumes the divided clock levels from the clock divider stage (clk_1hz, clk_10hz).
//  Resynchronises them into the clk domain as one-cycle tick strobes.
//  Runs a loadable countdown for the battle turn timer. Signals expiry to the game FSM.
// PARAMETERS
//  SEC_W      7   width of seconds counter
//  MAX_SEC    99  load clamp value, seconds
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      reset, asynchronous, active-low
//  clk_1hz_in   in   1      divided 1 Hz level from the divider, asynchronous to clk
//  clk_10hz_in  in   1      divided 10 Hz level from the divider, asynchronous to clk
//  load         in   1      pulse: load load_sec and go to IDLE (abort)
//  load_sec     in   SEC_W  seconds value to load
//  start        in   1      pulse: IDLE/PAUSED -> RUN
//  pause        in   1      pulse: RUN -> PAUSED
//  sec_left     out  SEC_W  remaining whole seconds
//  tenths_left  out  4      remaining tenths 0..9 (tied 0 without TENTHS_EN)
//  tick_1hz     out  1      one-cycle strobe per rising edge of clk_1hz_in
//  tick_10hz    out  1      one-cycle strobe per rising edge of clk_10hz_in
//  running      out  1      state == RUN
//  expired      out  1      one-cycle pulse on the first cycle in DONE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, synchroniser flops 0. Reset is asynchronous: clears immediately, in any state.
//  Sync: 2-FF synchroniser, then rising-edge detect register.
//   A tick strobe is high exactly 1 cycle, 3 clk cycles after the input rising edge.
//   Falling edges produce no strobe.
//  States: IDLE, RUN, PAUSED, DONE.
//  Priority per cycle: load > start > pause > tick.
//   load (any state): sec_left <= min(load_sec, MAX_SEC); tenths_left <= 0; state <= IDLE.
//   start in IDLE or PAUSED:
//    if count == 0, go to DONE;
//    otherwise go to RUN.
//   start in RUN or DONE: ignored.
//   pause in RUN: go to PAUSED; a tick arriving in the same cycle is still applied.
//   pause in any other state: ignored.
//   Ticks in IDLE, PAUSED or DONE: no effect on the count; strobes still output.
//  RUN decrement, without TENTHS_EN:
//   tick_1hz: sec_left <= sec_left - 1.
//   When the result is 0, state <= DONE in the same update.
//  RUN decrement, with TENTHS_EN:
//   tick_10hz decrements the combined sec.tenths count.
//   tenths 0 -> 9 with a borrow from sec_left.
//   Reaching 0.0 -> DONE.
//  The first tick after start may arrive anywhere in the tick period. The partial first period is accepted, not compensated.
//  DONE: count holds 0, expired high 1 cycle, DONE is held until load.
//  Counter never wraps below 0.
// CONFIGURATION
//  Macro TENTHS_EN:
//   defined: 0.1 s resolution driven by tick_10hz; tenths_left live.
//   undefined: 1 s resolution driven by tick_1hz; tenths_left = 0; 10 Hz sync chain still drives tick_10hz.
// STRUCTURE
//  Package battle_pkg: timer_state_t enum (IDLE, RUN, PAUSED, DONE), MAX_SEC, SEC_W defaults.
//  Sub-module tick_sync: 2-FF synchroniser + edge detect, async active-low reset; instantiated twice.
//  Top-level: FSM + down-counter.
// TESTING
//  Scale the divider inputs in the bench (toggle every N clk cycles).
//  Reset: rst_n=0 mid-RUN -> all outputs 0 immediately, state IDLE; release -> no spurious ticks.
//  Tick timing: one rising edge on clk_1hz_in -> tick_1hz high exactly 1 cycle, 3 cycles later; falling edge -> no strobe.
//  Countdown: load 3, start, 3 ticks -> sec_left 3,2,1,0 -> expired 1 cycle, running drops; further ticks -> no change.
//  Pause/resume: load 5, start, 2 ticks, pause, 4 ticks -> sec_left stays 3; start -> counts on to 0.
//  Edge cases:
//   load 120 -> sec_left 99.
//   load + start same cycle -> IDLE.
//   start with 0 loaded -> DONE, expired pulse.
//   start in DONE -> ignored.
//  TENTHS_EN build: load 1, start, 10 tick_10hz -> tenths/sec go 0.9, 0.8 ... 0.0, then expired.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared types and default sizing for the battle turn timer.
package battle_pkg;

    localparam int SEC_W_DEFAULT   = 7;
    localparam int MAX_SEC_DEFAULT = 99;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } timer_state_t;

endpackage

// File: rtl/tick_sync.sv
// Brings an asynchronous divider level into the clk domain and emits a
// registered one-cycle strobe for each rising edge of that level.
module tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic tick_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic tick_q;
    logic tick_d;

    assign tick_d = sync2_q & ~prev_q;

    // NOTE: non-blocking assignments let every flop sample the pre-edge value,
    // which is what makes this a shift chain rather than a single wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= level_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/battle_turn_timer.sv
// Battle turn countdown: synchronised 1 Hz / 10 Hz ticks drive a loadable timer.
// Define TENTHS_EN for 0.1 s resolution driven by the 10 Hz tick.
module battle_turn_timer
    import battle_pkg::*;
#(
    parameter int SEC_W   = SEC_W_DEFAULT,
    parameter int MAX_SEC = MAX_SEC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_1hz_in,
    input  logic             clk_10hz_in,
    input  logic             load,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             start,
    input  logic             pause,
    output logic [SEC_W-1:0] sec_left,
    output logic [3:0]       tenths_left,
    output logic             tick_1hz,
    output logic             tick_10hz,
    output logic             running,
    output logic             expired
);

    timer_state_t     state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [3:0]       tenths_q, tenths_d;
    logic             expired_q, expired_d;
    logic [SEC_W-1:0] load_clamped;
    logic             count_zero;
    logic             dec_tick;

    tick_sync u_sync_1hz (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (clk_1hz_in),
        .tick_o  (tick_1hz)
    );

    tick_sync u_sync_10hz (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (clk_10hz_in),
        .tick_o  (tick_10hz)
    );

`ifdef TENTHS_EN
    assign dec_tick = tick_10hz;
`else
    assign dec_tick = tick_1hz;
`endif

    assign load_clamped = (load_sec > SEC_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : load_sec;
    assign count_zero   = (sec_q == '0) && (tenths_q == 4'd0);

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        tenths_d  = tenths_q;
        expired_d = 1'b0;
        if (load) begin
            sec_d    = load_clamped;
            tenths_d = 4'd0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE, PAUSED: begin
                    if (start) begin
                        if (count_zero) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) state_d = PAUSED;
                    // A tick coinciding with pause still counts; reaching zero wins over pause.
                    if (dec_tick && !count_zero) begin
`ifdef TENTHS_EN
                        if (tenths_q == 4'd0) begin
                            tenths_d = 4'd9;
                            sec_d    = sec_q - 1'b1;
                        end else begin
                            tenths_d = tenths_q - 4'd1;
                        end
`else
                        sec_d = sec_q - 1'b1;
`endif
                        if ((sec_d == '0) && (tenths_d == 4'd0)) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sec_q     <= '0;
            tenths_q  <= 4'd0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            tenths_q  <= tenths_d;
            expired_q <= expired_d;
        end
    end

    assign sec_left    = sec_q;
    assign tenths_left = tenths_q;
    assign running     = (state_q == RUN);
    assign expired     = expired_q;

endmodule

// File: tb/tb_battle_turn_timer.sv
// Self-checking bench for battle_turn_timer against a remaining-time reference model.
module tb_battle_turn_timer;

`ifdef TENTHS_EN
    localparam int U = 10;
`else
    localparam int U = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_1hz_in = 1'b0;
    logic       clk_10hz_in = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_sec = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] sec_left;
    logic [3:0] tenths_left;
    logic       tick_1hz;
    logic       tick_10hz;
    logic       running;
    logic       expired;

    battle_turn_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_1hz_in  (clk_1hz_in),
        .clk_10hz_in (clk_10hz_in),
        .load        (load),
        .load_sec    (load_sec),
        .start       (start),
        .pause       (pause),
        .sec_left    (sec_left),
        .tenths_left (tenths_left),
        .tick_1hz    (tick_1hz),
        .tick_10hz   (tick_10hz),
        .running     (running),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 run, 2 paused, 3 done; remaining time in units.
    int m_mode;
    int m_rem;
    bit m_exp;
    bit m_t1, m_t10;
    bit h1 [4];
    bit h10[4];
    int exp_seen;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        m_mode = 0;
        m_rem  = 0;
        m_exp  = 0;
        m_t1   = 0;
        m_t10  = 0;
        for (int i = 0; i < 4; i++) begin
            h1[i]  = 0;
            h10[i] = 0;
        end
    endtask

    // One clock: capture the inputs presented at the edge, advance the model, settle.
    task automatic cycle();
        bit ld, st, ps, in1, in10, tk;
        int ls;
        ld = load; st = start; ps = pause; ls = int'(load_sec);
        in1 = clk_1hz_in; in10 = clk_10hz_in;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            tk = (U == 10) ? m_t10 : m_t1;
            m_exp = 0;
            if (ld) begin
                m_rem  = ((ls > 99) ? 99 : ls) * U;
                m_mode = 0;
            end else if (st && (m_mode == 0 || m_mode == 2)) begin
                if (m_rem == 0) begin
                    m_mode = 3;
                    m_exp  = 1;
                end else begin
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (ps) m_mode = 2;
                if (tk && m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_mode = 3;
                        m_exp  = 1;
                    end
                end
            end
            for (int i = 3; i > 0; i--) begin
                h1[i]  = h1[i-1];
                h10[i] = h10[i-1];
            end
            h1[0]  = in1;
            h10[0] = in10;
            // A strobe appears three edges after the level is first sampled high.
            m_t1  = h1[2]  && !h1[3];
            m_t10 = h10[2] && !h10[3];
        end
        #1;
        if (expired === 1'b1) exp_seen++;
    endtask

    function automatic logic [14:0] exp_vec();
        logic [6:0] s;
        logic [3:0] t;
        s = 7'(m_rem / U);
        t = 4'(m_rem % U);
        return {s, t, (m_mode == 1), m_exp, m_t1, m_t10};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {sec_left, tenths_left, running, expired, tick_1hz, tick_10hz};
    endfunction

    task automatic edge_1hz();
        clk_1hz_in = 1'b1;
        repeat (4) cycle();
        clk_1hz_in = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        load_sec = 7'(v);
        cycle();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (2) cycle();
        n_checks++;
        if (obs_vec() !== 15'd0) $display("FAIL reset_outputs got=%h want=0", obs_vec());
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_release got=%h want=%h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_tick_timing();
        logic [2:0] seen;
        logic [5:0] fall_seen;
        clk_1hz_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            seen[i] = tick_1hz;
        end
        n_checks++;
        if (seen !== 3'b100) $display("FAIL tick_rise_latency got=%b want=100", seen);
        else n_pass++;
        cycle();
        n_checks++;
        if (tick_1hz !== 1'b0) $display("FAIL tick_one_cycle got=%b want=0", tick_1hz);
        else n_pass++;
        clk_1hz_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            fall_seen[i] = tick_1hz;
        end
        n_checks++;
        if (fall_seen !== 6'd0) $display("FAIL tick_falling_edge got=%b want=0", fall_seen);
        else n_pass++;
    endtask

    task automatic test_countdown();
        int e0;
        do_load(3);
        do_start();
        n_checks++;
        if ({sec_left, running} !== {7'd3 * 7'(U == 1), 1'b1} && U == 1)
            $display("FAIL countdown_start got=%0d/%b want=3/1", sec_left, running);
        else n_pass++;
        e0 = exp_seen;
        for (int k = 1; k <= 3 * U; k++) begin
            if (U == 1) edge_1hz();
            else begin
                clk_10hz_in = 1'b1; repeat (3) cycle();
                clk_10hz_in = 1'b0; repeat (3) cycle();
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL countdown_step%0d got=%h want=%h", k, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({sec_left, tenths_left, running} !== 12'd0 || exp_seen - e0 !== 1)
            $display("FAIL countdown_end got=%0d.%0d run=%b exp=%0d want=0.0 run=0 exp=1",
                     sec_left, tenths_left, running, exp_seen - e0);
        else n_pass++;
        edge_1hz();
        n_checks++;
        if ({sec_left, running, expired} !== 9'd0) $display("FAIL done_holds got=%0d want=0", sec_left);
        else n_pass++;
    endtask

    task automatic test_pause_resume();
        int e0;
        do_load(5);
        do_start();
        if (U == 1) begin
            edge_1hz();
            edge_1hz();
            pause = 1'b1;
            cycle();
            pause = 1'b0;
            repeat (4) edge_1hz();
            n_checks++;
            if ({sec_left, running} !== {7'd3, 1'b0}) $display("FAIL pause_holds got=%0d run=%b want=3 run=0", sec_left, running);
            else n_pass++;
            e0 = exp_seen;
            do_start();
            repeat (3) edge_1hz();
            n_checks++;
            if (sec_left !== 7'd0 || exp_seen - e0 !== 1) $display("FAIL resume_to_zero got=%0d exp=%0d want=0 exp=1", sec_left, exp_seen - e0);
            else n_pass++;
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL pause_model got=%h want=%h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_edge_cases();
        do_load(120);
        n_checks++;
        if ({sec_left, tenths_left} !== {7'd99, 4'd0}) $display("FAIL load_clamp got=%0d want=99", sec_left);
        else n_pass++;
        load = 1'b1; start = 1'b1; load_sec = 7'd4;
        cycle();
        load = 1'b0; start = 1'b0;
        n_checks++;
        if ({sec_left, running, expired} !== {7'd4, 2'b00}) $display("FAIL load_start_same got=%0d run=%b want=4 run=0", sec_left, running);
        else n_pass++;
        do_load(0);
        do_start();
        n_checks++;
        if ({sec_left, running, expired} !== {7'd0, 2'b01}) $display("FAIL start_zero got=%b%b want=01", running, expired);
        else n_pass++;
        cycle();
        n_checks++;
        if (expired !== 1'b0) $display("FAIL expired_one_cycle got=%b want=0", expired);
        else n_pass++;
        do_start();
        n_checks++;
        if ({running, expired} !== 2'b00) $display("FAIL start_in_done got=%b%b want=00", running, expired);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [5:0] spur;
        do_load(9);
        do_start();
        clk_1hz_in = 1'b1;
        repeat (2) cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 15'd0) $display("FAIL async_reset got=%h want=0", obs_vec());
        else n_pass++;
        clk_1hz_in = 1'b0;
        clk_10hz_in = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            spur[i] = tick_1hz | tick_10hz | running;
        end
        n_checks++;
        if (spur !== 6'd0 || sec_left !== 7'd0) $display("FAIL reset_no_spurious got=%b sec=%0d want=0", spur, sec_left);
        else n_pass++;
    endtask

`ifdef TENTHS_EN
    task automatic test_tenths();
        int e0;
        do_load(1);
        do_start();
        e0 = exp_seen;
        for (int k = 1; k <= 10; k++) begin
            clk_10hz_in = 1'b1; repeat (4) cycle();
            clk_10hz_in = 1'b0; repeat (3) cycle();
            n_checks++;
            if ({sec_left, tenths_left} !== {7'd0, 4'(10 - k)}) $display("FAIL tenths_step%0d got=%0d.%0d want=0.%0d", k, sec_left, tenths_left, 10 - k);
            else n_pass++;
        end
        n_checks++;
        if (exp_seen - e0 !== 1) $display("FAIL tenths_expired got=%0d want=1", exp_seen - e0);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        int half1, half10, c1, c10, r, errs;
        half1 = 5; half10 = 2; c1 = 0; c10 = 0; errs = 0;
        do_load(6);
        do_start();
        for (int i = 0; i < 3000; i++) begin
            if (++c1 >= half1) begin
                c1 = 0;
                clk_1hz_in = ~clk_1hz_in;
                half1 = $urandom_range(2, 7);
            end
            if (++c10 >= half10) begin
                c10 = 0;
                clk_10hz_in = ~clk_10hz_in;
                half10 = $urandom_range(2, 3);
            end
            r = $urandom_range(0, 99);
            load = (r < 2);
            start = (r >= 2 && r < 8);
            pause = (r >= 8 && r < 11);
            load_sec = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 8));
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                if (errs < 10) $display("FAIL random_cycle%0d got=%h want=%h", i, obs_vec(), exp_vec());
                errs++;
            end else n_pass++;
        end
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        exp_seen = 0;
        test_reset();
        test_tick_timing();
        test_countdown();
        test_pause_resume();
        test_edge_cases();
        test_async_reset();
`ifdef TENTHS_EN
        test_tenths();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
